// File: rtl/load_handler.sv
// Read-side load engine: presents an address to the synchronous data memory,
// waits READ_LATENCY edges, then captures the word and holds it until released.
module load_handler #(
  parameter int DATA_WIDTH       = 8,
  parameter int DATA_MEMORY_SIZE = 64,
  parameter int READ_LATENCY     = 1,
  localparam int AW              = $clog2(DATA_MEMORY_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [AW-1:0]         src_addr,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [AW-1:0]         mem_addr_out,
  output logic                  mem_rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  ready,
  output logic                  busy
);

  // Handshake: enable is a level request held until ready is seen; ready stays
  // high with data_out valid until enable drops; enable low before ready aborts.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // READ_LATENCY==0 never enters WAIT, so its counter preload is irrelevant.
  localparam logic [3:0] CNT_INIT = 4'((READ_LATENCY == 0) ? 0 : READ_LATENCY - 1);

  state_t                state, state_nx;
  logic [3:0]            cnt, cnt_nx;
  logic [AW-1:0]         addr_nx;
  logic [DATA_WIDTH-1:0] data_nx;
  logic                  ready_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      mem_addr_out <= '0;
      data_out     <= '0;
      ready        <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      mem_addr_out <= addr_nx;
      data_out     <= data_nx;
      ready        <= ready_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    addr_nx  = mem_addr_out;
    data_nx  = data_out;
    ready_nx = ready;
    case (state)
      IDLE: begin
        ready_nx = 1'b0;
        if (enable) begin
          addr_nx  = src_addr;
          state_nx = REQ;
        end
      end
      REQ: begin
        if (!enable) begin
          state_nx = IDLE;
        end else if (READ_LATENCY == 0) begin
          data_nx  = mem_data_in;
          ready_nx = 1'b1;
          state_nx = DONE;
        end else begin
          cnt_nx   = CNT_INIT;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        // An abort wins even on the capture edge; the in-flight word is dropped.
        if (!enable) begin
          state_nx = IDLE;
        end else if (cnt != 4'd0) begin
          cnt_nx = cnt - 4'd1;
        end else begin
          data_nx  = mem_data_in;
          ready_nx = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        if (!enable) begin
          ready_nx = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy      = (state == REQ) || (state == WAIT);
  assign mem_rd_en = (state == REQ);

endmodule

// File: tb/tb_load_handler.sv
// Bench for load_handler: three builds (latency 0, 1, 3) share one stimulus stream
// and are checked every cycle against a transaction-level model of the load rules.
module tb_load_handler;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [5:0] src_addr;

  logic [7:0] mem [64];

  logic [7:0] mem_data_in  [3];
  logic [5:0] mem_addr_out [3];
  logic       mem_rd_en    [3];
  logic [7:0] data_out     [3];
  logic       ready        [3];
  logic       busy         [3];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  function automatic int lat_of(input int g);
    return (g == 0) ? 0 : ((g == 1) ? 1 : 3);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int RL = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    logic [7:0] pipe [16];

    load_handler #(
      .DATA_WIDTH      (8),
      .DATA_MEMORY_SIZE(64),
      .READ_LATENCY    (RL)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .src_addr    (src_addr),
      .mem_data_in (mem_data_in[g]),
      .mem_addr_out(mem_addr_out[g]),
      .mem_rd_en   (mem_rd_en[g]),
      .data_out    (data_out[g]),
      .ready       (ready[g]),
      .busy        (busy[g])
    );

    // Data memory: word read on the strobed edge, then delayed RL-1 more edges.
    always @(posedge clk) begin
      if (mem_rd_en[g]) pipe[0] <= mem[mem_addr_out[g]];
      for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
    end

    if (RL == 0) begin : g_comb
      assign mem_data_in[g] = mem[mem_addr_out[g]];
    end else begin : g_pipe
      assign mem_data_in[g] = pipe[RL-1];
    end
  end

  // Transaction model: a load accepted at edge E0 completes at E0+1+latency
  // provided enable is still high on every edge up to and including that one.
  bit         m_active [3];
  int         m_age    [3];
  logic [5:0] m_addr   [3];
  bit         m_ready  [3];
  logic [7:0] m_data   [3];

  always @(posedge clk or posedge rst) begin
    for (int g = 0; g < 3; g++) begin
      if (rst) begin
        m_active[g] = 1'b0;
        m_age[g]    = 0;
        m_addr[g]   = '0;
        m_ready[g]  = 1'b0;
        m_data[g]   = '0;
      end else if (m_ready[g]) begin
        if (!enable) m_ready[g] = 1'b0;
      end else if (m_active[g]) begin
        m_age[g] = m_age[g] + 1;
        if (!enable) begin
          m_active[g] = 1'b0;
        end else if (m_age[g] == lat_of(g) + 1) begin
          m_active[g] = 1'b0;
          m_ready[g]  = 1'b1;
          m_data[g]   = mem[m_addr[g]];
        end
      end else if (enable) begin
        m_active[g] = 1'b1;
        m_age[g]    = 0;
        m_addr[g]   = src_addr;
      end
    end
  end

  task automatic check(input string name, input int g, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[lat%0d] got=%0h exp=%0h t=%0t", name, lat_of(g), act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int g = 0; g < 3; g++) begin
        check("ready", g, 32'(ready[g]), 32'(m_ready[g]));
        check("busy", g, 32'(busy[g]), 32'(m_active[g]));
        check("mem_rd_en", g, 32'(mem_rd_en[g]), 32'(m_active[g] && m_age[g] == 0));
        check("mem_addr_out", g, 32'(mem_addr_out[g]), 32'(m_addr[g]));
        check("data_out", g, 32'(data_out[g]), 32'(m_data[g]));
      end
    end
  end

  task automatic expect_all_zero(input string tag);
    for (int g = 0; g < 3; g++) begin
      check({tag, "_ready"}, g, 32'(ready[g]), 32'd0);
      check({tag, "_busy"}, g, 32'(busy[g]), 32'd0);
      check({tag, "_rd_en"}, g, 32'(mem_rd_en[g]), 32'd0);
      check({tag, "_addr"}, g, 32'(mem_addr_out[g]), 32'd0);
      check({tag, "_data"}, g, 32'(data_out[g]), 32'd0);
    end
  endtask

  task automatic step_edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int lat    [3];
  int pulses [3];

  initial begin
    rst      = 1'b1;
    enable   = 1'b0;
    src_addr = '0;
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[5]  = 8'hA7;
    mem[9]  = 8'h3C;
    mem[3]  = 8'h5E;
    mem[63] = 8'hC1;

    repeat (2) @(posedge clk);
    #1;
    expect_all_zero("reset");
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // Single load at address 5; address switches to 9 right after acceptance.
    step_edges(1);
    enable   = 1'b1;
    src_addr = 6'd5;
    for (int g = 0; g < 3; g++) begin
      lat[g]    = -1;
      pulses[g] = 0;
    end
    @(posedge clk);
    #1;
    src_addr = 6'd9;
    for (int g = 0; g < 3; g++) pulses[g] += int'(mem_rd_en[g]);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 3; g++) begin
        if (ready[g] && lat[g] < 0) lat[g] = k;
        pulses[g] += int'(mem_rd_en[g]);
      end
    end
    check("latency", 0, 32'(lat[0]), 32'd1);
    check("latency", 1, 32'(lat[1]), 32'd2);
    check("latency", 2, 32'(lat[2]), 32'd4);
    for (int g = 0; g < 3; g++) begin
      check("rd_pulses_held", g, 32'(pulses[g]), 32'd1);
      check("load5_data", g, 32'(data_out[g]), 32'hA7);
      check("load5_ready_held", g, 32'(ready[g]), 32'd1);
    end
    #1 enable = 1'b0;
    @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      check("release_ready", g, 32'(ready[g]), 32'd0);
      check("release_data", g, 32'(data_out[g]), 32'hA7);
    end

    // Back-to-back: address 3, one idle cycle, then the top word.
    #1;
    enable   = 1'b1;
    src_addr = 6'd3;
    step_edges(7);
    for (int g = 0; g < 3; g++) check("b2b_first", g, 32'(data_out[g]), 32'h5E);
    enable = 1'b0;
    step_edges(1);
    enable   = 1'b1;
    src_addr = 6'd63;
    step_edges(7);
    for (int g = 0; g < 3; g++) begin
      check("b2b_second", g, 32'(data_out[g]), 32'hC1);
      check("b2b_ready", g, 32'(ready[g]), 32'd1);
    end
    enable = 1'b0;
    step_edges(2);

    // Abort: enable drops before the latency-1 and latency-3 builds complete.
    enable   = 1'b1;
    src_addr = 6'd9;
    step_edges(2);
    enable = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      check("abort_ready", 2, 32'(ready[2]), 32'd0);
      check("abort_ready", 1, 32'(ready[1]), 32'd0);
    end
    check("abort_data", 2, 32'(data_out[2]), 32'hC1);
    check("abort_data", 1, 32'(data_out[1]), 32'hC1);
    #1;

    // Asynchronous reset in the middle of a load.
    enable   = 1'b1;
    src_addr = 6'd5;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    expect_all_zero("midreset");
    @(posedge clk);
    #2;
    rst    = 1'b0;
    enable = 1'b0;
    step_edges(1);

    // Random phase: toggling request level, wandering address, rare resets.
    repeat (1500) begin
      @(posedge clk);
      #2;
      if ($urandom_range(0, 99) < 20) enable = ~enable;
      src_addr = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 149) == 0) begin
        #5 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
      end
    end

    enable = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
